mux_4by1: RTL and testbench
===========================

Name: mux_4by1

Overview:
Registered 4-to-1 multiplexer. Two select bits (s1 = MSB, s0 = LSB) pick one of four data inputs i0..i3. The selected value is presented on output f after one clock edge. It is used as a generic clocked selection element in datapaths that need a glitch-free, registered mux output.

Parameters:
WIDTH, 1, bit width of each data input i0..i3 and of output f (legal range 1..64).

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
s1  input  1  select MSB
s0  input  1  select LSB
i0  input  WIDTH  data input, chosen when {s1,s0} = 2'b00
i1  input  WIDTH  data input, chosen when {s1,s0} = 2'b01
i2  input  WIDTH  data input, chosen when {s1,s0} = 2'b10
i3  input  WIDTH  data input, chosen when {s1,s0} = 2'b11
f  output  WIDTH  registered mux output

Behaviour:
- Select decode: sel = {s1,s0}.
  - 00 -> i0
  - 01 -> i1
  - 10 -> i2
  - 11 -> i3
- Output register: on each rising clk edge with rst_n = 1, f <= value chosen by the sel and data inputs sampled at that edge.
- Latency is exactly 1 clock from input change to f change. There is no combinational path from any input to f.
- Reset: on a rising edge with rst_n = 0, f <= 0 (all WIDTH bits). Reset takes priority over the data path.
  - Asserting rst_n between edges has no effect until the next rising edge.
  - Deasserting reset: the first edge with rst_n = 1 loads the normal mux result.
- Reset mid-operation: f clears on the reset edge regardless of sel or data. It resumes normal selection on the first non-reset edge. There is no other retained state.
- Unselected inputs have no effect on f; toggling them never changes f.
- Simultaneous change of sel and data before an edge: f reflects the new sel applied to the new data at that edge.
- X/Z on s1 or s0: the implementation must not infer latches. Simulation output for unknown sel is don't-care, but synthesis must treat sel as a full case with no default latch.
- Output f is driven only from the register. It holds its value between edges and is stable for a full clock period.
- Width rule: data path is bit-for-bit with no arithmetic; bit k of f comes from bit k of the selected input.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with sel=00, i0=1 -> f=0. Release rst_n -> f=1 after the next rising edge.
- Select 00: s1=0 s0=0 i0=1 i1=0 i2=0 i3=0 -> f=1 one clock later. Then set i1=i2=i3=1 with i0=1 -> f stays 1. Then set i0=0 -> f=0 next edge.
- Walk selects, one-hot data on the selected input, 100 time units per step (≥1 clock each):
  - sel=01, i1=1, others 0 -> f=1
  - sel=10, i2=1, others 0 -> f=1
  - sel=11, i3=1, others 0 -> f=1
  - Each check happens one edge after the change; f=0 if the one-hot bit is moved to any unselected input.
- Latency check: change sel from 00 to 11 with i0=1 and i3=0 between edges -> f remains 1 until the next edge, then becomes 0; no mid-cycle change.
- Mid-operation reset: sel=11, i3=1, f=1. Pulse rst_n=0 for one edge -> f=0 on that edge. Return to f=1 on the following edge with rst_n=1.
- WIDTH=8: i0=8'hA5 i1=8'h3C i2=8'hFF i3=8'h00, cycle sel 00,01,10,11 -> f = A5, 3C, FF, 00 on successive edges, each one clock delayed.

Source files
------------

// File: rtl/mux_4by1.sv
// Registered 4-to-1 multiplexer: {s1,s0} selects i0..i3, and f updates one clock later.
// Each bit is a separate lane, so bit k of f depends only on bit k of the inputs.

module mux_4by1_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_sel,
  input  logic [3:0] i_d,
  output logic       o_q
);
  logic w_mux;
  logic r_q;

  // All four codes are listed, so no latch is inferred and there is no default branch.
  always_comb begin
    w_mux = 1'b0;
    unique case (i_sel)
      2'b00: w_mux = i_d[0];
      2'b01: w_mux = i_d[1];
      2'b10: w_mux = i_d[2];
      2'b11: w_mux = i_d[3];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= w_mux;
  end

  assign o_q = r_q;
endmodule

module mux_4by1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] f
);
  logic [1:0] w_sel;
  assign w_sel = {s1, s0};

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    mux_4by1_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_sel (w_sel),
      .i_d   ({i3[k], i2[k], i1[k], i0[k]}),
      .o_q   (f[k])
    );
  end
endmodule

// File: tb/tb_mux_4by1.sv
// Directed table-driven bench for mux_4by1 (WIDTH=8), plus hand-written latency and reset sequences.

module tb_mux_4by1;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s1, s0;
  logic [W-1:0] i0, i1, i2, i3;
  logic [W-1:0] f;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         rst_n;
    logic [1:0]   sel;
    logic [W-1:0] d0, d1, d2, d3;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  mux_4by1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s1    (s1),
    .s0    (s0),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .f     (f)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic r, logic [1:0] sel,
                              logic [W-1:0] a, logic [W-1:0] b,
                              logic [W-1:0] c, logic [W-1:0] d,
                              logic [W-1:0] e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.sel = sel;
    v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: f=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [1:0] sel, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] c, logic [W-1:0] d);
    rst_n = r; {s1, s0} = sel; i0 = a; i1 = b; i2 = c; i3 = d;
  endtask

  initial begin
    drive(1'b0, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);

    vecs.push_back(mk("reset_0",     0, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("reset_1",     0, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("reset_rel",   1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk("sel00_i0",    1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk("sel00_allhi", 1, 2'b00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
    vecs.push_back(mk("sel00_i0lo",  1, 2'b00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00));
    vecs.push_back(mk("sel01_hot",   1, 2'b01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01));
    vecs.push_back(mk("sel01_unsel", 1, 2'b01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00));
    vecs.push_back(mk("sel10_hot",   1, 2'b10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01));
    vecs.push_back(mk("sel10_unsel", 1, 2'b10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00));
    vecs.push_back(mk("sel11_hot",   1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01));
    vecs.push_back(mk("sel11_unsel", 1, 2'b11, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk("w8_sel00",    1, 2'b00, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hA5));
    vecs.push_back(mk("w8_sel01",    1, 2'b01, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h3C));
    vecs.push_back(mk("w8_sel10",    1, 2'b10, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hFF));
    vecs.push_back(mk("w8_sel11",    1, 2'b11, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00));
    vecs.push_back(mk("w8_bits",     1, 2'b10, 8'h0F, 8'hF0, 8'h5A, 8'hC3, 8'h5A));
    vecs.push_back(mk("mid_set",     1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01));
    vecs.push_back(mk("mid_rst",     0, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00));
    vecs.push_back(mk("mid_resume",  1, 2'b11, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01));
    vecs.push_back(mk("simul_chg",   1, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22));

    // Inputs change on the falling edge, and f is sampled 1 time unit after the rising edge.
    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].rst_n, vecs[n].sel, vecs[n].d0, vecs[n].d1, vecs[n].d2, vecs[n].d3);
      @(posedge clk); #1;
      chk(vecs[n].name, f, vecs[n].exp);
    end

    // Latency: sel moves 00->11 mid-cycle; f must hold until the next edge.
    @(negedge clk);
    drive(1'b1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk("lat_pre", f, 8'h01);
    #1 {s1, s0} = 2'b11;
    #1 chk("lat_hold_a", f, 8'h01);
    @(negedge clk);
    chk("lat_hold_b", f, 8'h01);
    @(posedge clk); #1;
    chk("lat_after", f, 8'h00);

    // Reset asserted between edges takes effect only at the next edge.
    @(negedge clk);
    drive(1'b1, 2'b10, 8'h00, 8'h00, 8'h77, 8'h00);
    @(posedge clk); #1;
    chk("rst_mid_pre", f, 8'h77);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_hold", f, 8'h77);
    @(posedge clk); #1;
    chk("rst_mid_edge", f, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_rel", f, 8'h77);

    // Toggling unselected inputs never changes f.
    @(negedge clk);
    drive(1'b1, 2'b01, 8'h00, 8'h96, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i0 = 8'($urandom); i2 = 8'($urandom); i3 = 8'($urandom);
      @(posedge clk); #1;
      chk("unsel_toggle", f, 8'h96);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
